// File: rtl/token_matcher_pkg.sv
// Shared types and helpers for token_matcher: FSM states, null word, ASCII fold
// constants and the per-character compare mask builder.
package token_matcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam int MAX_WORD_BITS = 1024;
    localparam logic [MAX_WORD_BITS-1:0] NULL_WORD = '0;

    localparam logic [7:0] FOLD_LO  = 8'h41;
    localparam logic [7:0] FOLD_HI  = 8'h5A;
    localparam logic [7:0] FOLD_BIT = 8'h20;

    // Character c takes part in the compare when it lies inside the effective
    // length; a length of 0 or beyond the word means a full-word compare.
    function automatic logic char_in_mask(input int unsigned c,
                                          input int unsigned len,
                                          input int unsigned word_len);
        int unsigned eff;
        eff = (len == 0 || len > word_len) ? word_len : len;
        return c < eff;
    endfunction

endpackage

// File: rtl/token_matcher_scan_counter.sv
// Scan address counter for token_matcher: clear, enable, and a terminal flag at
// DEPTH-1 where it saturates instead of wrapping.
module scan_counter
    import token_matcher_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  terminal
);

    assign terminal = (cnt == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !terminal) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/token_matcher.sv
// Vocabulary matcher: sequential pipelined scan of an internal word RAM for the
// first exact/prefix match. Define TOKEN_MATCHER_CASE_FOLD_EN for ASCII case folding.
module token_matcher
    import token_matcher_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_data,
    input  logic                              q_valid,
    output logic                              q_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] q_word,
    input  logic [LEN_WIDTH-1:0]              q_len,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              res_hit,
    output logic [ADDR_WIDTH-1:0]             res_index,
    output logic                              res_overflow,
    output logic                              busy
);

    localparam int WORD_BITS = WORD_LENGTH * DATA_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    // Handshakes: a query transfers on q_valid & q_ready, a result on
    // res_valid & res_ready; result outputs hold steady while res_valid waits.
    state_t state, state_n;

    logic [WORD_BITS-1:0]   mem [DEPTH];
    logic [WORD_BITS-1:0]   rd_data;
    logic [WORD_BITS-1:0]   q_word_r;
    logic [WORD_LENGTH-1:0] mask_r, q_mask;
    logic [ADDR_WIDTH-1:0]  cnt, cmp_idx;
    logic                   terminal, issue, issued_last, cmp_valid;
    logic                   hit_r, hit_n, ovf_r, ovf_n;
    logic [ADDR_WIDTH-1:0]  idx_r, idx_n;
    logic [WORD_LENGTH-1:0] char_eq;
    logic                   accept, entry_null, entry_hit, entry_last;

    assign accept = (state == ST_IDLE) && q_valid;
    assign issue  = (state == ST_SCAN) && !issued_last;

    scan_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ST_IDLE),
        .en      (issue),
        .cnt     (cnt),
        .terminal(terminal)
    );

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr_en) mem[wr_addr] <= wr_data;
        if (issue) rd_data <= mem[cnt];
    end

    function automatic logic [DATA_WIDTH-1:0] fold_char(input logic [DATA_WIDTH-1:0] ch);
        logic [DATA_WIDTH-1:0] r;
        r = ch;
`ifdef TOKEN_MATCHER_CASE_FOLD_EN
        if (ch[7:0] >= FOLD_LO && ch[7:0] <= FOLD_HI) r[7:0] = ch[7:0] | FOLD_BIT;
`endif
        return r;
    endfunction

    for (genvar c = 0; c < WORD_LENGTH; c++) begin : g_char
        localparam int HI = (WORD_LENGTH - c) * DATA_WIDTH - 1;
        assign q_mask[c]  = char_in_mask(c, 32'(q_len), WORD_LENGTH);
        assign char_eq[c] = !mask_r[c] ||
                            (fold_char(q_word_r[HI -: DATA_WIDTH]) == fold_char(rd_data[HI -: DATA_WIDTH]));
    end

    assign entry_null = (rd_data == NULL_WORD[WORD_BITS-1:0]);
    assign entry_hit  = (&char_eq) && !entry_null;
    assign entry_last = (cmp_idx == {ADDR_WIDTH{1'b1}});

    always_comb begin
        state_n = state;
        hit_n   = hit_r;
        idx_n   = idx_r;
        ovf_n   = ovf_r;
        case (state)
            ST_IDLE: if (accept) state_n = ST_SCAN;
            ST_SCAN: begin
                if (cmp_valid && (entry_hit || entry_null || entry_last)) begin
                    state_n = ST_RESULT;
                    hit_n   = entry_hit;
                    idx_n   = entry_hit ? cmp_idx : '0;
                    ovf_n   = !entry_hit && !entry_null;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_n = ST_IDLE;
                    hit_n   = 1'b0;
                    idx_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hit_r       <= 1'b0;
            idx_r       <= '0;
            ovf_r       <= 1'b0;
            q_word_r    <= '0;
            mask_r      <= '0;
            cmp_idx     <= '0;
            cmp_valid   <= 1'b0;
            issued_last <= 1'b0;
        end else begin
            state     <= state_n;
            hit_r     <= hit_n;
            idx_r     <= idx_n;
            ovf_r     <= ovf_n;
            cmp_valid <= issue;
            if (issue) cmp_idx <= cnt;
            if (accept) begin
                q_word_r <= q_word;
                mask_r   <= q_mask;
            end
            // Once DEPTH-1 has been read the counter is saturated; stop issuing.
            if (state != ST_SCAN)       issued_last <= 1'b0;
            else if (issue && terminal) issued_last <= 1'b1;
        end
    end

    assign q_ready      = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign res_valid    = (state == ST_RESULT);
    assign res_hit      = hit_r;
    assign res_index    = idx_r;
    assign res_overflow = ovf_r;

endmodule

// File: tb/tb_token_matcher.sv
// Self-checking bench for token_matcher against a behavioural vocabulary model.
module tb_token_matcher;

    localparam int AW    = 4;
    localparam int WL    = 3;
    localparam int DW    = 8;
    localparam int LW    = 2;
    localparam int WB    = WL * DW;
    localparam int DEPTH = 2 ** AW;

    localparam logic [WB-1:0] W_CAT = 24'h636174;
    localparam logic [WB-1:0] W_HEL = 24'h48656C;
    localparam logic [WB-1:0] W_DOG = 24'h646F67;
    localparam logic [WB-1:0] W_HEX = 24'h486578;
    localparam logic [WB-1:0] W_ZZZ = 24'h7A7A7A;
    localparam logic [WB-1:0] W_HEL_UP = 24'h48454C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WB-1:0] wr_data = '0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [WB-1:0] q_word = '0;
    logic [LW-1:0] q_len = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_hit;
    logic [AW-1:0] res_index;
    logic          res_overflow;
    logic          busy;

    int tests_run = 0;
    int fails = 0;
    logic [WB-1:0] vocab [DEPTH];
    logic [AW+1:0] exp_q[$];

    token_matcher #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .q_valid(q_valid), .q_ready(q_ready), .q_word(q_word), .q_len(q_len),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
        .res_index(res_index), .res_overflow(res_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_char(input logic [WB-1:0] w, input int c);
        logic [7:0] ch;
        ch = w[(WL - 1 - c) * DW +: DW];
`ifdef TOKEN_MATCHER_CASE_FOLD_EN
        if (ch >= 8'h41 && ch <= 8'h5A) ch = ch + 8'h20;
`endif
        return ch;
    endfunction

    task automatic model_scan(input logic [WB-1:0] word, input int len,
                              output logic hit, output logic [AW-1:0] idx,
                              output logic ovf, output int lat);
        int eff;
        bit same;
        eff = (len == 0 || len > WL) ? WL : len;
        hit = 1'b0; idx = '0; ovf = 1'b1; lat = DEPTH + 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (vocab[i] == '0) begin
                ovf = 1'b0; lat = i + 2;
                return;
            end
            same = 1'b1;
            for (int c = 0; c < eff; c++)
                if (model_char(word, c) != model_char(vocab[i], c)) same = 1'b0;
            if (same) begin
                hit = 1'b1; idx = AW'(i); ovf = 1'b0; lat = i + 2;
                return;
            end
        end
    endtask

    function automatic logic [WB-1:0] rand_word(input int alpha);
        logic [WB-1:0] w;
        logic [7:0] set4 [4];
        set4[0] = 8'h61; set4[1] = 8'h62; set4[2] = 8'h41; set4[3] = 8'h42;
        for (int c = 0; c < WL; c++)
            w[c * DW +: DW] = (alpha == 0) ? set4[$urandom_range(0, 3)] : 8'($urandom_range(8'h61, 8'h79));
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [WB-1:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        vocab[addr] = data;
    endtask

    task automatic load_small_vocab();
        write_word(0, W_CAT);
        write_word(1, W_HEL);
        write_word(2, W_DOG);
        write_word(3, '0);
    endtask

    task automatic do_query(input string name, input logic [WB-1:0] word, input int len,
                            input int hold, input bit wr_during);
        logic e_hit, e_ovf;
        logic [AW-1:0] e_idx;
        logic [AW+1:0] exp, snap;
        int e_lat, cyc;
        bit got;
        model_scan(word, len, e_hit, e_idx, e_ovf, e_lat);
        exp_q.push_back({e_hit, e_idx, e_ovf});
        tests_run++;
        if (q_ready !== 1'b1) begin
            fails++; $display("FAIL %s q_ready_idle got=%b exp=1", name, q_ready);
        end
        q_valid = 1'b1; q_word = word; q_len = LW'(len);
        @(posedge clk); #1;
        q_valid = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            if (wr_during) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = W_ZZZ;
            end
            @(posedge clk); #1;
            cyc++;
            if (res_valid === 1'b1) got = 1'b1;
        end
        wr_en = 1'b0;
        exp = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            fails++; $display("FAIL %s timeout res_valid never rose within 40 cycles", name);
            return;
        end
        if (cyc != e_lat) begin
            fails++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, e_lat);
        end
        tests_run++;
        if ({res_hit, res_index, res_overflow} !== exp) begin
            fails++;
            $display("FAIL %s result got hit=%b idx=%0d ovf=%b exp hit=%b idx=%0d ovf=%b",
                     name, res_hit, res_index, res_overflow, exp[AW+1], exp[AW:1], exp[0]);
        end
        snap = {res_hit, res_index, res_overflow};
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (res_valid !== 1'b1 || q_ready !== 1'b0 || busy !== 1'b1 ||
                {res_hit, res_index, res_overflow} !== snap) begin
                fails++;
                $display("FAIL %s hold_cycle%0d got valid=%b qrdy=%b busy=%b res=%h exp valid=1 qrdy=0 busy=1 res=%h",
                         name, k, res_valid, q_ready, busy, {res_hit, res_index, res_overflow}, snap);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests_run++;
        if (res_valid !== 1'b0 || q_ready !== 1'b1) begin
            fails++; $display("FAIL %s after_handshake got valid=%b qrdy=%b exp valid=0 qrdy=1",
                              name, res_valid, q_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({q_ready, res_valid, res_hit, res_index, res_overflow, busy} !== {1'b1, 1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state got qrdy=%b valid=%b hit=%b idx=%0d ovf=%b busy=%b exp 1 0 0 0 0 0",
                     q_ready, res_valid, res_hit, res_index, res_overflow, busy);
        end
    endtask

    task automatic test_exact();
        load_small_vocab();
        do_query("exact_hel", W_HEL, 3, 0, 1'b0);
        do_query("exact_dog_len0", W_DOG, 0, 0, 1'b0);
        do_query("exact_cat", W_CAT, 3, 0, 1'b0);
    endtask

    task automatic test_prefix();
        do_query("prefix_hex2", W_HEX, 2, 0, 1'b0);
        do_query("prefix_hex3_miss", W_HEX, 3, 0, 1'b0);
        do_query("prefix_d1", 24'h64FFFF, 1, 0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), rand_word(1));
        do_query("overflow_zzz", W_ZZZ, 3, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_query("hold_and_write", vocab[5], 3, 5, 1'b1);
        do_query("requery_zzz", W_ZZZ, 3, 0, 1'b0);
        do_query("requery_entry0", vocab[0], 3, 0, 1'b0);
    endtask

    task automatic test_reset_midscan();
        load_small_vocab();
        q_valid = 1'b1; q_word = W_ZZZ; q_len = 2'd3;
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (res_valid !== 1'b0 || q_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL midscan_reset got valid=%b qrdy=%b busy=%b exp 0 1 0",
                              res_valid, q_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_query("after_reset_dog", W_DOG, 3, 0, 1'b0);
    endtask

    task automatic test_case_fold();
        do_query("fold_HEL", W_HEL_UP, 3, 0, 1'b0);
        do_query("fold_CAT_prefix", 24'h434100, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), rand_word(0));
        for (int n = 0; n < 24; n++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            write_word(AW'(a), ($urandom_range(0, 7) == 0) ? '0 : rand_word(0));
            do_query($sformatf("random_%0d", n), rand_word(0), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) vocab[i] = '0;
        test_reset();
        test_exact();
        test_prefix();
        test_overflow();
        test_back_to_back();
        test_reset_midscan();
        test_case_fold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/token_matcher.md
Name: token_matcher

Overview:
- Parametrised successor to the single-word vocab matcher: holds a vocabulary of fixed-length character words in an internal RAM and answers match queries by sequential scan.
- Each query is a word plus a match length. Supports exact match and prefix match of the first q_len characters.
- Returns first-hit index, hit flag and exhaustion status over valid/ready handshakes.
- Sits between the tokeniser front end and the embedding lookup in the tensor core input path.

Parameters:
- ADDR_WIDTH, 4, vocab address width; DEPTH = 2**ADDR_WIDTH entries
- WORD_LENGTH, 3, characters per word
- DATA_WIDTH, 8, bits per character
- LEN_WIDTH, $clog2(WORD_LENGTH+1), width of q_len

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  vocab write strobe; ignored while busy=1
- wr_addr  in  ADDR_WIDTH  vocab write address
- wr_data  in  WORD_LENGTH*DATA_WIDTH  vocab word; char 0 in MSBs
- q_valid  in  1  query valid
- q_ready  out  1  query accepted when q_valid&q_ready
- q_word  in  WORD_LENGTH*DATA_WIDTH  query word; char 0 in MSBs
- q_len  in  LEN_WIDTH  characters compared from char 0; 0 or >WORD_LENGTH means WORD_LENGTH (exact)
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid&res_ready
- res_hit  out  1  match found
- res_index  out  ADDR_WIDTH  index of first matching entry; 0 on miss
- res_overflow  out  1  scan hit DEPTH-1 with no match and no null terminator
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; q_ready=1, res_valid=0, res_hit=0, res_index=0, res_overflow=0, busy=0. RAM contents are not reset. Reset mid-scan aborts the query with no result.
- RAM: single-port write, synchronous read, 1-cycle read latency. Write has priority only in IDLE; wr_en while busy is dropped.
- A null entry is all-zero. It terminates the scan as a miss.
- FSM states:
  - IDLE: q_ready=1. On accept, latch q_word and effective length into a per-character mask; issue read of addr 0; go SCAN.
  - SCAN: pipelined, one entry per cycle. In cycle k, read addr k is issued and entry k-1 is compared. Compare = masked equality of first L chars.
    - Hit at i: go RESULT with hit=1, index=i.
    - Null at i: go RESULT with hit=0.
    - i=DEPTH-1 without hit/null: go RESULT with hit=0, overflow=1.
    - Hit is checked before null. A null entry never matches, even in prefix mode.
    - The address counter does not wrap; reads past DEPTH-1 are never issued.
  - RESULT: res_valid=1, outputs stable until res_ready. On handshake go IDLE; q_ready rises the following cycle.
- Latency: with query accepted at edge T, hit/terminator at index i gives res_valid high after edge T+i+2. Worst case is DEPTH+1 cycles.
- Lowest matching index wins when duplicates exist.
- q_ready=0 in SCAN and RESULT; no query queuing.

Optional Feature:
- TOKEN_MATCHER_CASE_FOLD_EN
- Defined: ASCII 'A'..'Z' (8'h41..8'h5A) are mapped to lowercase on both query and stored characters before comparison. Only the low 8 bits of each char are examined when DATA_WIDTH>8. Folding is combinational in the compare stage and adds no latency.
- Undefined: raw bitwise comparison.

Decomposition:
- token_matcher_pkg holds:
  - state enum typedef (IDLE, SCAN, RESULT)
  - NULL_WORD constant helper
  - ASCII fold constants (8'h41, 8'h5A, 8'h20)
  - function building the character mask from length
- One sub-module: scan_counter. Address counter with clear, enable and a terminal flag at DEPTH-1. Non-wrapping; saturates.

Test Plan:
- Load entries 0:"cat", 1:"Hel", 2:"dog", 3:0. Query "Hel", q_len=3 -> res_hit=1, res_index=1, res_valid at T+3.
- Same vocab. Query "Hex", q_len=2 -> res_hit=1, res_index=1. Query "Hex", q_len=3 -> res_hit=0, res_overflow=0 (null at index 3).
- Fill all 16 entries non-null without "zzz". Query "zzz" -> res_hit=0, res_overflow=1, res_valid at T+17.
- Hold res_ready=0 for 5 cycles in RESULT -> outputs stable, q_ready=0. Also assert wr_en during scan -> RAM unchanged (verify by re-query).
- Deassert rst_n during SCAN -> res_valid=0, q_ready=1 immediately. Re-query "dog" -> hit index 2 (RAM preserved).
- With TOKEN_MATCHER_CASE_FOLD_EN defined: query "HEL" -> hit index 1. Without the macro: miss.
